// File: rtl/tdm_pkg.sv
// Shared types and sizing helpers for the TDM demultiplexer.
// Counter widths never drop below one bit, even for two-entry counters.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } tdm_state_e;

  localparam int DEF_N_CH = 4;
  localparam int DEF_W    = 8;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_bit_slot_ctr.sv
// Bit and slot position tracker for the TDM demultiplexer.
// Commands take effect only on qualified beats; clear wins over sync load, which wins over advance.
module tdm_bit_slot_ctr
  import tdm_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int W    = DEF_W,
  localparam int BIT_CW  = cnt_width(W),
  localparam int SLOT_CW = cnt_width(N_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bit_en,
  input  logic               adv,
  input  logic               load_sync,
  input  logic               clear,
  output logic [SLOT_CW-1:0] slot_cnt,
  output logic               word_last,
  output logic               frame_last,
  output logic               at_sync_pos
);

  logic [BIT_CW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [SLOT_CW-1:0] slot_cnt_q, slot_cnt_d;

  assign word_last   = (bit_cnt_q == BIT_CW'(W - 1));
  assign frame_last  = word_last && (slot_cnt_q == SLOT_CW'(N_CH - 1));
  assign at_sync_pos = (bit_cnt_q == '0) && (slot_cnt_q == '0);
  assign slot_cnt    = slot_cnt_q;

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    slot_cnt_d = slot_cnt_q;
    if (bit_en) begin
      if (clear) begin
        bit_cnt_d  = '0;
        slot_cnt_d = '0;
      end else if (load_sync) begin
        // The sync beat itself is bit 0 of slot 0, so the next beat is bit 1.
        bit_cnt_d  = BIT_CW'(1);
        slot_cnt_d = '0;
      end else if (adv) begin
        if (word_last) begin
          bit_cnt_d  = '0;
          slot_cnt_d = frame_last ? '0 : slot_cnt_q + SLOT_CW'(1);
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q  <= '0;
      slot_cnt_q <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      slot_cnt_q <= slot_cnt_d;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// Serial TDM demultiplexer: locks to frame sync, shifts slot words in MSB first
// and latches each completed word into its channel register with a one-clock valid pulse.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int W    = DEF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              din,
  input  logic              fsync,
  output logic [N_CH*W-1:0] ch_data,
  output logic [N_CH-1:0]   ch_valid,
  output logic              frame_done,
  output logic              locked,
  output logic              sync_err
);

  localparam int SLOT_CW = cnt_width(N_CH);

  tdm_state_e state_q, state_d;

  // Only the W-1 most recent bits are stored; the current din completes the word.
  logic [W-2:0]      shift_q, shift_d;
  logic [W-1:0]      word_d;
  logic [W-1:0]      ch_data_q [N_CH];
  logic [W-1:0]      ch_data_d [N_CH];
  logic [N_CH-1:0]   ch_valid_q, ch_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              sync_err_q, sync_err_d;

  logic               ctr_adv, ctr_load_sync, ctr_clear;
  logic [SLOT_CW-1:0] slot_cnt;
  logic               word_last, frame_last, at_sync_pos;

  tdm_bit_slot_ctr #(
    .N_CH (N_CH),
    .W    (W)
  ) u_ctr (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_en      (bit_en),
    .adv         (ctr_adv),
    .load_sync   (ctr_load_sync),
    .clear       (ctr_clear),
    .slot_cnt    (slot_cnt),
    .word_last   (word_last),
    .frame_last  (frame_last),
    .at_sync_pos (at_sync_pos)
  );

  assign word_d = {shift_q, din};

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    ch_data_d     = ch_data_q;
    ch_valid_d    = '0;
    frame_done_d  = 1'b0;
    sync_err_d    = 1'b0;
    ctr_adv       = 1'b0;
    ctr_load_sync = 1'b0;
    ctr_clear     = 1'b0;

    if (bit_en) begin
      if (state_q == HUNT) begin
        if (fsync) begin
          state_d       = LOCK;
          shift_d       = (W-1)'(din);
          ctr_load_sync = 1'b1;
        end
      end else begin
        if (fsync && !at_sync_pos) begin
          // Sync arrived off position: drop the partial word and restart the frame here.
          sync_err_d    = 1'b1;
          shift_d       = (W-1)'(din);
          ctr_load_sync = 1'b1;
        end else if (!fsync && at_sync_pos) begin
          sync_err_d = 1'b1;
          state_d    = HUNT;
          shift_d    = '0;
          ctr_clear  = 1'b1;
        end else begin
          shift_d = word_d[W-2:0];
          ctr_adv = 1'b1;
          if (word_last) begin
            for (int k = 0; k < N_CH; k++) begin
              if (slot_cnt == SLOT_CW'(k)) begin
                ch_data_d[k]  = word_d;
                ch_valid_d[k] = 1'b1;
              end
            end
            frame_done_d = frame_last;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      shift_q      <= '0;
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        ch_data_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      ch_valid_q   <= ch_valid_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      for (int k = 0; k < N_CH; k++) begin
        ch_data_q[k] <= ch_data_d[k];
      end
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_pack
    assign ch_data[gi*W +: W] = ch_data_q[gi];
  end

  assign ch_valid   = ch_valid_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state_q == LOCK);

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: frame table, hand-written corner sequences,
// and randomized beats checked every cycle against a frame-position reference model.
module tb_tdm_demux;

  localparam int N_CH = 4;
  localparam int W    = 8;
  localparam int FB   = N_CH * W;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            bit_en;
  logic            din;
  logic            fsync;
  logic [FB-1:0]   ch_data;
  logic [N_CH-1:0] ch_valid;
  logic            frame_done;
  logic            locked;
  logic            sync_err;

  tdm_demux #(.N_CH(N_CH), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_en     (bit_en),
    .din        (din),
    .fsync      (fsync),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: lock flag, position within the frame, and the bits gathered so far.
  bit              m_locked;
  int              m_pos;
  int              m_acc;
  logic [W-1:0]    m_data [N_CH];
  logic [N_CH-1:0] m_valid;
  bit              m_done;
  bit              m_err;

  int obs_valid, obs_err, obs_done;

  typedef struct {
    logic [FB-1:0] words;
    int            period;
    logic [FB-1:0] exp_data;
    int            exp_valid;
    int            exp_err;
    logic          exp_locked;
  } fvec_t;

  fvec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_pos    = 0;
    m_acc    = 0;
    m_valid  = '0;
    m_done   = 0;
    m_err    = 0;
    for (int k = 0; k < N_CH; k++) m_data[k] = '0;
  endtask

  task automatic model_beat(input logic be, input logic d, input logic fs);
    int slot;
    m_valid = '0;
    m_done  = 0;
    m_err   = 0;
    if (!be) return;
    if (!m_locked) begin
      if (fs) begin
        m_locked = 1;
        m_pos    = 1;
        m_acc    = int'(d);
      end
    end else if (fs && m_pos != 0) begin
      m_err = 1;
      m_pos = 1;
      m_acc = int'(d);
    end else if (!fs && m_pos == 0) begin
      m_err    = 1;
      m_locked = 0;
      m_acc    = 0;
    end else begin
      m_acc = (m_acc * 2 + int'(d)) % (1 << W);
      m_pos++;
      if (m_pos % W == 0) begin
        slot          = m_pos / W - 1;
        m_data[slot]  = m_acc[W-1:0];
        m_valid[slot] = 1'b1;
        if (m_pos == FB) begin
          m_done = 1;
          m_pos  = 0;
        end
      end
    end
  endtask

  function automatic logic [FB-1:0] model_packed();
    logic [FB-1:0] p;
    for (int k = 0; k < N_CH; k++) p[k*W +: W] = m_data[k];
    return p;
  endfunction

  // Drive one clk of stimulus (called just after a falling edge) and check outputs at the next falling edge.
  task automatic step(input logic be, input logic d, input logic fs);
    bit_en = be;
    din    = d;
    fsync  = fs;
    @(posedge clk);
    model_beat(be, d, fs);
    @(negedge clk);
    check("ch_data",    64'(ch_data),    64'(model_packed()));
    check("ch_valid",   64'(ch_valid),   64'(m_valid));
    check("frame_done", 64'(frame_done), 64'(m_done));
    check("sync_err",   64'(sync_err),   64'(m_err));
    check("locked",     64'(locked),     64'(m_locked));
    obs_valid += $countones(ch_valid);
    obs_err   += int'(sync_err);
    obs_done  += int'(frame_done);
    if (|ch_valid)
      $display("t=%0t word: ch_valid=%b ch_data=%h frame_done=%b", $time, ch_valid, ch_data, frame_done);
  endtask

  task automatic send_frame(input logic [FB-1:0] words, input int period, input logic fs_first,
                            input int nbeats);
    logic [FB-1:0] w;
    w = words;
    for (int b = 0; b < nbeats; b++) begin
      for (int p = 1; p < period; p++) step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
      step(1'b1, w[(b / W) * W + (W - 1 - b % W)], (b == 0) && fs_first);
    end
  endtask

  task automatic clear_obs();
    obs_valid = 0;
    obs_err   = 0;
    obs_done  = 0;
  endtask

  task automatic check_frame(input string tag, input logic [FB-1:0] exp_data, input int exp_valid,
                             input int exp_err, input logic exp_locked);
    check({tag, "_data"},   64'(ch_data),   64'(exp_data));
    check({tag, "_nvalid"}, 64'(obs_valid), 64'(exp_valid));
    check({tag, "_nerr"},   64'(obs_err),   64'(exp_err));
    check({tag, "_locked"}, 64'(locked),    64'(exp_locked));
    $display("%s: ch_data=%h valids=%0d errs=%0d locked=%b", tag, ch_data, obs_valid, obs_err, locked);
  endtask

  initial begin
    vecs[0] = '{32'h01FF3CA5, 1, 32'h01FF3CA5, 4, 0, 1'b1};
    vecs[1] = '{32'h01FF3C11, 1, 32'h01FF3C11, 4, 0, 1'b1};
    vecs[2] = '{32'h01FF3C22, 1, 32'h01FF3C22, 4, 0, 1'b1};
    vecs[3] = '{32'h01FF3C33, 1, 32'h01FF3C33, 4, 0, 1'b1};
    vecs[4] = '{32'h01FF3CA5, 3, 32'h01FF3CA5, 4, 0, 1'b1};

    rst_n  = 1'b0;
    bit_en = 1'b0;
    din    = 1'b0;
    fsync  = 1'b0;
    model_reset();
    clear_obs();
    @(negedge clk);
    @(negedge clk);
    check("reset_data",  64'(ch_data),    64'h0);
    check("reset_valid", 64'(ch_valid),   64'h0);
    check("reset_done",  64'(frame_done), 64'h0);
    check("reset_lock",  64'(locked),     64'h0);
    check("reset_err",   64'(sync_err),   64'h0);
    rst_n = 1'b1;

    // Clean, back-to-back and strobed frames.
    for (int i = 0; i < 5; i++) begin
      clear_obs();
      send_frame(vecs[i].words, vecs[i].period, 1'b1, FB);
      check_frame($sformatf("frame%0d", i), vecs[i].exp_data, vecs[i].exp_valid,
                  vecs[i].exp_err, vecs[i].exp_locked);
      check($sformatf("frame%0d_ndone", i), 64'(obs_done), 64'd1);
    end

    // Early sync at bit 3 of slot 2.
    clear_obs();
    send_frame(32'hCAFE1234, 1, 1'b1, 19);
    check_frame("early_partial", 32'h01FF1234, 2, 0, 1'b1);
    clear_obs();
    send_frame(32'h0BADF00D, 1, 1'b1, FB);
    check_frame("early_refr", 32'h0BADF00D, 4, 1, 1'b1);

    // Missed sync at the start of a frame, then recovery.
    clear_obs();
    send_frame(32'h55AA55AA, 1, 1'b0, FB);
    check_frame("missed", 32'h0BADF00D, 0, 1, 1'b0);
    clear_obs();
    send_frame(32'h76543210, 1, 1'b1, FB);
    check_frame("recover", 32'h76543210, 4, 0, 1'b1);

    // Asynchronous reset in slot 1, between clock edges.
    send_frame(32'h13572468, 1, 1'b1, 12);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_data",  64'(ch_data),  64'h0);
    check("arst_lock",  64'(locked),   64'h0);
    check("arst_valid", 64'(ch_valid), 64'h0);
    check("arst_err",   64'(sync_err), 64'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    send_frame(32'hFFFFFFFF, 1, 1'b0, FB);
    check_frame("post_rst", 32'h0, 0, 0, 1'b0);

    // Randomized beats: sync mostly on position, occasionally early, late or missing.
    for (int i = 0; i < 3000; i++) begin
      logic be, fs;
      be = ($urandom_range(3) != 0);
      if (!m_locked)        fs = ($urandom_range(5) == 0);
      else if (m_pos == 0)  fs = ($urandom_range(11) != 0);
      else                  fs = ($urandom_range(99) == 0);
      step(be, 1'($urandom_range(1)), fs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
